serial_adder_ctrl: RTL and testbench

//  Bit-serial N-bit adder built around a single gate-level full-adder cell.

---
 rtl/serial_adder_ctrl_pkg.sv | 34 +++
 rtl/serial_adder_ctrl_fa_cell.sv | 16 +
 rtl/serial_adder_ctrl.sv | 139 +++++++++++++
 tb/tb_serial_adder_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared definitions for the bit-serial adder: state encoding, width limits
// and small helpers used by the sequencer.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_FIN   = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic int cnt_width(input int w);
        return (w <= 2) ? 1 : $clog2(w);
    endfunction

    function automatic bit width_ok(input int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

    // Ripple increment built from xor/and so the only adder is the serial cell.
    function automatic logic [31:0] inc_bits(input logic [31:0] v);
        logic [31:0] res;
        logic        c;
        c = 1'b1;
        for (int i = 0; i < 32; i++) begin
            res[i] = v[i] ^ c;
            c      = c & v[i];
        end
        return res;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa_cell.sv
// Gate-level full adder cell; the single arithmetic element of the serial adder.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s
);

    logic w_xy_xor;

    assign w_xy_xor = x ^ y;
    assign s        = w_xy_xor ^ cin;
    assign cout     = (x & y) | (cin & w_xy_xor);

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: captures operands on start, feeds one bit pair
// per cycle LSB first through fa_cell, and presents sum/cout with a done pulse.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = cnt_width(WIDTH);

    if (!width_ok(WIDTH)) begin : g_width_check
        $error("serial_adder_ctrl: WIDTH out of range 2..32");
    end

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_sh_a;
    logic [WIDTH-1:0]   r_sh_b;
    logic [WIDTH-1:0]   r_sh_s;
    logic               r_carry;
    logic [CNT_W-1:0]   r_count;
    logic [CNT_W-1:0]   w_count_inc;
    logic               w_last;
    logic               w_cell_s;
    logic               w_cell_cout;
    logic               r_busy;
    logic               r_done;
    logic [WIDTH-1:0]   r_sum;
    logic               r_cout;

    fa_cell u_fa_cell (
        .x    (r_sh_a[0]),
        .y    (r_sh_b[0]),
        .cin  (r_carry),
        .cout (w_cell_cout),
        .s    (w_cell_s)
    );

    assign w_count_inc = CNT_W'(inc_bits(32'(r_count)));
    assign w_last      = (r_count == CNT_W'(WIDTH - 1));

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_SHIFT;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (w_last) begin
                    w_state_nxt = ST_FIN;
                end else begin
                    w_state_nxt = ST_SHIFT;
                end
            end
            ST_FIN:  w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // State register with busy/done registered from the next state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_done  <= (w_state_nxt == ST_FIN);
        end
    end

    // Datapath: operand capture, serial shift, carry flop and bit counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh_a  <= {WIDTH{1'b0}};
            r_sh_b  <= {WIDTH{1'b0}};
            r_sh_s  <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_count <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_sh_a  <= a;
                        r_sh_b  <= b;
                        r_carry <= 1'b0;
                        r_count <= {CNT_W{1'b0}};
                    end
                end
                ST_SHIFT: begin
                    r_sh_a  <= {1'b0, r_sh_a[WIDTH-1:1]};
                    r_sh_b  <= {1'b0, r_sh_b[WIDTH-1:1]};
                    r_sh_s  <= {w_cell_s, r_sh_s[WIDTH-1:1]};
                    r_carry <= w_cell_cout;
                    r_count <= w_count_inc;
                end
                default: begin
                    r_carry <= r_carry;
                end
            endcase
        end
    end

    // Result registers load on FIN entry, taking the final bit straight from the cell.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sum  <= {WIDTH{1'b0}};
            r_cout <= 1'b0;
        end else if ((r_state == ST_SHIFT) && w_last) begin
            r_sum  <= {w_cell_s, r_sh_s[WIDTH-1:1]};
            r_cout <= w_cell_cout;
        end else begin
            r_sum  <= r_sum;
            r_cout <= r_cout;
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8 and WIDTH=4 against an
// arithmetic reference (a+b, fixed WIDTH+1 cycle latency).
module tb_serial_adder_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start8, busy8, done8, cout8;
    logic [7:0] a8, b8, sum8;
    logic       start4, busy4, done4, cout4;
    logic [3:0] a4, b4, sum4;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [63:0] last_res8 = 64'd0;
    logic [63:0] last_res4 = 64'd0;

    always #5 clk = ~clk;

    serial_adder_ctrl #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
    );

    serial_adder_ctrl #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic sample(input int w, output logic dn, output logic bs, output logic [63:0] res);
        if (w == 8) begin
            dn = done8; bs = busy8; res = {55'd0, cout8, sum8};
        end else begin
            dn = done4; bs = busy4; res = {59'd0, cout4, sum4};
        end
    endtask

    // One transaction: start pulse, wait for done, check latency/result/holding.
    task automatic run_op(input int w, input logic [31:0] opa, input logic [31:0] opb, input bit scramble);
        logic [63:0] exp;
        logic [63:0] prev;
        logic [63:0] res;
        logic        dn, bs;
        int          cyc;
        exp  = (64'(opa) + 64'(opb)) & ((64'd1 << (w + 1)) - 64'd1);
        prev = (w == 8) ? last_res8 : last_res4;
        @(negedge clk);
        if (w == 8) begin
            start8 = 1'b1; a8 = opa[7:0]; b8 = opb[7:0];
        end else begin
            start4 = 1'b1; a4 = opa[3:0]; b4 = opb[3:0];
        end
        @(negedge clk);
        start8 = 1'b0; start4 = 1'b0;
        cyc = 1;
        sample(w, dn, bs, res);
        while (!dn && cyc < 3 * w) begin
            check_val("busy_in_op", 64'(bs), 64'd1);
            check_val("result_stable", res, prev);
            if (scramble) begin
                a8 = 8'($urandom); b8 = 8'($urandom);
                a4 = 4'($urandom); b4 = 4'($urandom);
            end
            @(negedge clk);
            cyc++;
            sample(w, dn, bs, res);
        end
        check_val("done_seen", 64'(dn), 64'd1);
        check_val("latency", 64'(cyc), 64'(w + 1));
        check_val("result", res, exp);
        check_val("busy_with_done", 64'(bs), 64'd1);
        if (w == 8) last_res8 = exp; else last_res4 = exp;
        @(negedge clk);
        sample(w, dn, bs, res);
        check_val("done_one_cycle", 64'(dn), 64'd0);
        check_val("idle_after_done", 64'(bs), 64'd0);
        check_val("result_held", res, exp);
    endtask

    initial begin
        logic [63:0] res;
        logic        dn, bs;
        int          n_done, first_c, second_c;

        rst = 1'b1; start8 = 1'b0; start4 = 1'b0;
        a8 = 8'd0; b8 = 8'd0; a4 = 4'd0; b4 = 4'd0;
        repeat (3) @(negedge clk);
        check_val("rst_busy8", 64'(busy8), 64'd0);
        check_val("rst_done8", 64'(done8), 64'd0);
        check_val("rst_res8", {55'd0, cout8, sum8}, 64'd0);
        check_val("rst_busy4", 64'(busy4), 64'd0);
        check_val("rst_res4", {59'd0, cout4, sum4}, 64'd0);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_val("idle_no_start", 64'(busy8), 64'd0);

        run_op(8, 32'h5A, 32'h33, 1'b0);
        run_op(8, 32'hFF, 32'h01, 1'b0);
        run_op(8, 32'h00, 32'h00, 1'b0);

        // Start held high for 20 cycles: only accepts from IDLE count.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'h10; b8 = 8'h20;
        n_done = 0; first_c = 0; second_c = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            sample(8, dn, bs, res);
            if (dn) begin
                n_done++;
                if (n_done == 1) first_c = k; else second_c = k;
                check_val("held_result", res, 64'h30);
            end
        end
        start8 = 1'b0;
        check_val("held_done_count", 64'(n_done), 64'd2);
        check_val("held_first_done", 64'(first_c), 64'd9);
        check_val("held_second_done", 64'(second_c), 64'd19);
        last_res8 = 64'h30;
        repeat (2) @(negedge clk);

        // Reset mid-operation, with start asserted alongside rst.
        @(negedge clk);
        start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
        @(negedge clk);
        start8 = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1; start8 = 1'b1;
        @(negedge clk);
        rst = 1'b0; start8 = 1'b0;
        sample(8, dn, bs, res);
        check_val("abort_busy", 64'(bs), 64'd0);
        check_val("abort_done", 64'(dn), 64'd0);
        check_val("abort_res", res, 64'd0);
        last_res8 = 64'd0;
        n_done = 0;
        repeat (12) begin
            @(negedge clk);
            if (done8 || busy8) n_done++;
        end
        check_val("abort_quiet", 64'(n_done), 64'd0);
        run_op(8, 32'hAA, 32'h55, 1'b0);

        for (int i = 0; i < 40; i++) begin
            run_op(8, $urandom & 32'hFF, $urandom & 32'hFF, 1'b1);
        end

        for (int x = 0; x < 16; x++) begin
            for (int y = 0; y < 16; y++) begin
                run_op(4, 32'(x), 32'(y), (y % 2) == 1);
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
